// File: rtl/write_addr_trace_pkg.sv
// Shared register map, STATUS bit positions and trace-word packing for the
// write-address trace debugger.
package write_addr_trace_pkg;

   localparam logic [1:0] ADDR_TRACE   = 2'd0;
   localparam logic [1:0] ADDR_PART_EN = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_ID      = 2'd3;

   localparam int STATUS_CLEAR_BIT      = 0;
   localparam int STATUS_FREEZE_WR_BIT  = 1;
   localparam int STATUS_OVERFLOW_BIT   = 16;
   localparam int STATUS_FREEZE_BIT     = 17;
   localparam int STATUS_SEQ_LSB        = 32;

   localparam logic [15:0] ID_MAGIC = 16'hDB61;

   // Callers zero-extend seq and dbg to 24 bits, so unused field bits read 0.
   function automatic logic [63:0] pack_trace(input logic [23:0] seq, input logic [23:0] dbg);
      return {1'b1, 7'b0, seq, 8'b0, dbg};
   endfunction

endpackage

// File: rtl/write_addr_trace_debugger_trace_fifo.sv
// Synchronous trace FIFO with clear; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 13
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     push_accepted
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty         = (count == '0);
   assign full          = (count == FULL_COUNT);
   assign head_data     = mem[rd_ptr];
   assign do_pop        = pop && !empty;
   assign do_push       = push && !clear && (!full || do_pop);
   assign push_accepted = do_push;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/write_addr_trace_debugger.sv
// Avalon-MM debug slave: traces debug-info changes into a FIFO and owns the
// partition write-enable register. Optional freeze control: TRACE_FREEZE_EN.
module write_addr_trace_debugger #(
   parameter int PARTITIONS = 5,
   parameter int DBG_W      = 5,
   parameter int DEPTH      = 16,
   parameter int SEQ_W      = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            io_Avalon_address,
   input  logic                  io_Avalon_read,
   output logic [63:0]           io_Avalon_readdata,
   output logic                  io_Avalon_readdatavalid,
   input  logic                  io_Avalon_write,
   input  logic [63:0]           io_Avalon_writedata,
   output logic                  io_Avalon_waitrequest,
   output logic [PARTITIONS-1:0] io_PartitionWriteEnables,
   input  logic [DBG_W-1:0]      io___dbgInfo
);

   import write_addr_trace_pkg::*;

   localparam int EW = SEQ_W + DBG_W;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [SEQ_W-1:0]      seq;
   logic [DBG_W-1:0]      prev_dbg;
   logic                  overflow;
   logic                  freeze;
   logic                  change;
   logic                  capture;
   logic                  rd_trace;
   logic                  clear;
   logic [EW-1:0]         head_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CW-1:0]         fifo_count;
   logic                  push_accepted;
   logic [63:0]           rd_word;
   logic                  unused_wdata;

   assign io_Avalon_waitrequest = 1'b0;
   assign unused_wdata          = ^{io_Avalon_writedata, fifo_full};

   assign change   = (io___dbgInfo != prev_dbg);
   assign capture  = change && !freeze;
   assign rd_trace = io_Avalon_read && (io_Avalon_address == ADDR_TRACE);
   assign clear    = io_Avalon_write && (io_Avalon_address == ADDR_STATUS)
                     && io_Avalon_writedata[STATUS_CLEAR_BIT];

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clock         (clock),
      .reset         (reset),
      .push          (capture),
      .pop           (rd_trace),
      .clear         (clear),
      .push_data     ({seq, io___dbgInfo}),
      .head_data     (head_data),
      .full          (fifo_full),
      .empty         (fifo_empty),
      .count         (fifo_count),
      .push_accepted (push_accepted)
   );

   // A clear in the same cycle as a dropped push still leaves overflow clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         seq                      <= SEQ_W'(1);
         prev_dbg                 <= '0;
         overflow                 <= 1'b0;
         io_PartitionWriteEnables <= '0;
      end else begin
         prev_dbg <= io___dbgInfo;
         if (capture)
            seq <= seq + SEQ_W'(1);
         if (clear)
            overflow <= 1'b0;
         else if (capture && !push_accepted)
            overflow <= 1'b1;
         if (io_Avalon_write && (io_Avalon_address == ADDR_PART_EN))
            io_PartitionWriteEnables <= io_Avalon_writedata[PARTITIONS-1:0];
      end
   end

`ifdef TRACE_FREEZE_EN
   always_ff @(posedge clock) begin
      if (reset)
         freeze <= 1'b0;
      else if (io_Avalon_write && (io_Avalon_address == ADDR_STATUS))
         freeze <= io_Avalon_writedata[STATUS_FREEZE_WR_BIT];
   end
`else
   assign freeze = 1'b0;
`endif

   always_comb begin
      rd_word = '0;
      case (io_Avalon_address)
         ADDR_TRACE: begin
            if (!fifo_empty)
               rd_word = pack_trace(24'(head_data[EW-1:DBG_W]), 24'(head_data[DBG_W-1:0]));
         end
         ADDR_PART_EN: rd_word[PARTITIONS-1:0] = io_PartitionWriteEnables;
         ADDR_STATUS: begin
            rd_word[8:0]                                = 9'(fifo_count);
            rd_word[STATUS_OVERFLOW_BIT]                = overflow;
            rd_word[STATUS_FREEZE_BIT]                  = freeze;
            rd_word[STATUS_SEQ_LSB+7:STATUS_SEQ_LSB]    = 8'(seq);
         end
         ADDR_ID: rd_word = {ID_MAGIC, 8'(DEPTH-1), 8'(PARTITIONS), 8'(DBG_W), 8'(SEQ_W), 16'h0};
         default: rd_word = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         io_Avalon_readdata      <= '0;
         io_Avalon_readdatavalid <= 1'b0;
      end else begin
         io_Avalon_readdatavalid <= io_Avalon_read;
         if (io_Avalon_read)
            io_Avalon_readdata <= rd_word;
      end
   end

endmodule

// File: doc/write_addr_trace_debugger.md
Name: write_addr_trace_debugger

Overview:
Parametrised Avalon-MM debug slave, successor to the single-register write-address verifier debugger. Captures every change of the verifier's debug-info bus, stamped with a rolling sequence number, into a DEPTH-entry trace FIFO readable by host pop. Also owns the per-partition write-enable register that gates the verifier partitions. Sits on the host debug Avalon bus beside the writing-address verifier.

Parameters:
PARTITIONS, 5, number of partition write-enable bits (1..32)
DBG_W, 5, width of debug-info bus (1..24)
DEPTH, 16, trace FIFO entries; power of two, 2..256
SEQ_W, 8, sequence-number width (1..24)

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
io_Avalon_address  in  2  64-bit word address
io_Avalon_read  in  1  read strobe
io_Avalon_readdata  out  64  read data, valid with readdatavalid
io_Avalon_readdatavalid  out  1  high exactly 1 cycle after an accepted read
io_Avalon_write  in  1  write strobe
io_Avalon_writedata  in  64  write data
io_Avalon_waitrequest  out  1  constant 0
io_PartitionWriteEnables  out  PARTITIONS  partition write enables
io___dbgInfo  in  DBG_W  verifier debug info

Behaviour:
- Reset (synchronous, active-high): FIFO empty, overflow=0, seq=1, prev_dbg=0, enables=0, readdata=0, readdatavalid=0, freeze=0. Reset mid-transfer drops any pending read; no readdatavalid follows.
- Capture: each cycle io___dbgInfo != prev_dbg -> prev_dbg<=io___dbgInfo, seq<=seq+1 (wraps mod 2^SEQ_W, wraps through 0), push entry {seq, io___dbgInfo} (current seq, pre-increment).
- Full FIFO, no pop the same cycle: entry dropped, overflow sticky set; seq and prev_dbg still update.
- Full FIFO with pop the same cycle: push accepted.
- Register map (reads: 1-cycle latency, registered; writes: take effect next cycle):
  - addr 0 TRACE (RO, pop): bit63=valid, bits[32+SEQ_W-1:32]=seq, bits[DBG_W-1:0]=dbg, other bits 0. Read on non-empty pops the head. Read on empty returns all-zero and does not pop.
  - addr 1 PART_EN (RW): bits[PARTITIONS-1:0] = enables; unused bits read 0.
  - addr 2 STATUS: read bits[8:0]=occupancy, bit16=overflow, bit17=freeze, bits[39:32]=current seq (zero-extended, truncated to 8 if SEQ_W>8). Write bit0=1 clears FIFO and overflow. Write bit1 sets freeze (freeze feature only).
  - addr 3 ID (RO): {16'hDB61, 8'(DEPTH-1), 8'(PARTITIONS), 8'(DBG_W), 8'(SEQ_W), 16'h0}.
- Read and write in the same cycle: both performed.
- Writes to addr 0 or 3: ignored.
- Clear in the same cycle as a capture push: clear wins; the entry is lost; seq/prev_dbg still update. Clear does not reset seq.
- Clear with a pop in the same cycle: pop returns the head data; FIFO then empty.

Optional Feature:
Macro TRACE_FREEZE_EN.
- Defined: STATUS bit1 write sets freeze, write of 0 clears it. While frozen, no pushes and seq holds; prev_dbg keeps tracking, so no burst occurs on unfreeze. Reads/pops still work.
- Undefined: bit1 write ignored; STATUS bit17 reads 0.

Decomposition:
- Package write_addr_trace_pkg:
  - register address localparams (TRACE/PART_EN/STATUS/ID)
  - STATUS bit positions
  - ID magic 16'hDB61
  - function packing a trace entry into a 64-bit word
- Sub-module trace_fifo: sync FIFO, DEPTH x (SEQ_W+DBG_W); push/pop/clear, full/empty/count; push-when-full-with-pop allowed.

Test Plan:
- Reset, then read addr 3 with defaults -> readdata 64'hDB61_0F05_0508_0000 one cycle later; waitrequest always 0.
- dbgInfo 0->3->3->7, then 3 reads of addr 0 -> {valid,seq=1,dbg=3}, {valid,seq=2,dbg=7}, then 0 (empty, no pop).
- 17 distinct dbg changes, no reads -> STATUS occupancy=16, overflow=1; first pop seq=1; STATUS seq=18.
- Write PART_EN 64'hFFFF_FFFF_FFFF_FFFF -> io_PartitionWriteEnables=5'h1F next cycle; read addr 1 -> 64'h1F.
- FIFO full with pop and dbg change in the same cycle -> push accepted, occupancy stays 16, overflow unchanged. Then write STATUS 1 -> occupancy 0, overflow 0.
- TRACE_FREEZE_EN: set freeze, toggle dbg 4 times, unfreeze -> occupancy unchanged, seq unchanged. Without the macro -> 4 entries captured and bit17=0.
